// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants, hex table and decode result type
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {CA..CG} pattern for each hex digit, indexed by nibble value
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       unknown;
  } seg_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low segment pattern to hex nibble decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o = '0;
    if (seg_i == SEG_BLANK) begin
      dec_o.blank = 1'b1;
    end else begin
      dec_o.unknown = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (seg_i == HEX_TABLE[i]) begin
          dec_o.nibble  = 4'(i);
          dec_o.unknown = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - rebuilds the eight displayed hex digits from a scanned 7-segment bus
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        CLK100,
  input  logic        resetn,
  input  logic [7:0]  an_i,
  input  logic [6:0]  seg_i,
  output logic [31:0] value_o,
  output logic [7:0]  blank_o,
  output logic [7:0]  unknown_o,
  output logic        frame_valid_o,
  output logic        an_err_o
);

  localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [14:0]      prev_q, prev_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             armed_q, armed_d;
  logic [7:0]       got_q, got_d;
  logic [31:0]      sh_nib_q, sh_nib_d;
  logic [7:0]       sh_blank_q, sh_blank_d, sh_unk_q, sh_unk_d;
  logic [31:0]      value_q, value_d;
  logic [7:0]       blank_q, blank_d, unknown_q, unknown_d;
  logic             frame_valid_q, frame_valid_d;
  logic             an_err_q, an_err_d;

  logic [14:0]      sample;
  logic             fire;
  logic [3:0]       low_cnt;
  logic [2:0]       an_idx;
  seg_dec_t         dec;

  seg7_decode u_decode (
    .seg_i (seg_s2_q),
    .dec_o (dec)
  );

  always_comb begin
    an_s1_d    = an_i;
    seg_s1_d   = seg_i;
    an_s2_d    = an_s1_q;
    seg_s2_d   = seg_s1_q;
    sample     = {an_s2_q, seg_s2_q};
    prev_d     = sample;
    stab_cnt_d = stab_cnt_q;
    armed_d    = armed_q;
    fire       = 1'b0;

    // One capture per dwell: armed drops on capture and only a change re-arms it
    if (sample != prev_q) begin
      stab_cnt_d = '0;
      armed_d    = 1'b1;
    end else begin
      if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + CNT_W'(1);
      if (armed_q && stab_cnt_q == STAB_LAST) begin
        fire    = 1'b1;
        armed_d = 1'b0;
      end
    end

    low_cnt = '0;
    an_idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_s2_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        an_idx  = 3'(i);
      end
    end

    got_d         = got_q;
    sh_nib_d      = sh_nib_q;
    sh_blank_d    = sh_blank_q;
    sh_unk_d      = sh_unk_q;
    value_d       = value_q;
    blank_d       = blank_q;
    unknown_d     = unknown_q;
    frame_valid_d = 1'b0;
    an_err_d      = an_err_q;

    // Publish first so a same-cycle capture lands in the freshly cleared frame
    if (got_q == 8'hFF) begin
      value_d       = sh_nib_q;
      blank_d       = sh_blank_q;
      unknown_d     = sh_unk_q;
      frame_valid_d = 1'b1;
      got_d         = '0;
    end

    if (fire && low_cnt == 4'd1) begin
      got_d[an_idx]                 = 1'b1;
      sh_nib_d[{an_idx, 2'b00} +: 4] = dec.nibble;
      sh_blank_d[an_idx]            = dec.blank;
      sh_unk_d[an_idx]              = dec.unknown;
    end else if (fire && low_cnt > 4'd1) begin
      an_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      an_s1_q       <= '1;
      an_s2_q       <= '1;
      seg_s1_q      <= '1;
      seg_s2_q      <= '1;
      prev_q        <= '1;
      stab_cnt_q    <= '0;
      armed_q       <= 1'b1;
      got_q         <= '0;
      sh_nib_q      <= '0;
      sh_blank_q    <= '0;
      sh_unk_q      <= '0;
      value_q       <= '0;
      blank_q       <= 8'hFF;
      unknown_q     <= '0;
      frame_valid_q <= 1'b0;
      an_err_q      <= 1'b0;
    end else begin
      an_s1_q       <= an_s1_d;
      an_s2_q       <= an_s2_d;
      seg_s1_q      <= seg_s1_d;
      seg_s2_q      <= seg_s2_d;
      prev_q        <= prev_d;
      stab_cnt_q    <= stab_cnt_d;
      armed_q       <= armed_d;
      got_q         <= got_d;
      sh_nib_q      <= sh_nib_d;
      sh_blank_q    <= sh_blank_d;
      sh_unk_q      <= sh_unk_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      unknown_q     <= unknown_d;
      frame_valid_q <= frame_valid_d;
      an_err_q      <= an_err_d;
    end
  end

  assign value_o       = value_q;
  assign blank_o       = blank_q;
  assign unknown_o     = unknown_q;
  assign frame_valid_o = frame_valid_q;
  assign an_err_o      = an_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - directed bench for seg7_scan_capture
module tb_seg7_scan_capture;

  logic        CLK100 = 1'b0;
  logic        resetn;
  logic [7:0]  an_i;
  logic [6:0]  seg_i;
  logic [31:0] value_o;
  logic [7:0]  blank_o;
  logic [7:0]  unknown_o;
  logic        frame_valid_o;
  logic        an_err_o;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int frame_cnt = 0;
  int base;
  logic [31:0] last_val;
  logic [7:0]  last_blank, last_unk;

  logic [6:0] hex_seg [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan_capture #(.STABLE_CYCLES(16), .CNT_W(8)) dut (
    .CLK100        (CLK100),
    .resetn        (resetn),
    .an_i          (an_i),
    .seg_i         (seg_i),
    .value_o       (value_o),
    .blank_o       (blank_o),
    .unknown_o     (unknown_o),
    .frame_valid_o (frame_valid_o),
    .an_err_o      (an_err_o)
  );

  always #5 CLK100 = ~CLK100;

  always @(negedge CLK100) begin
    if (frame_valid_o) begin
      frame_cnt  = frame_cnt + 1;
      last_val   = value_o;
      last_blank = blank_o;
      last_unk   = unknown_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic show(input int pos, input logic [6:0] seg, input int dwell);
    an_i  = ~(8'h01 << pos);
    seg_i = seg;
    repeat (dwell) @(negedge CLK100);
  endtask

  task automatic idle(input int cycles);
    an_i  = 8'hFF;
    seg_i = 7'b1111111;
    repeat (cycles) @(negedge CLK100);
  endtask

  task automatic scan(input logic [31:0] word);
    for (int i = 0; i < 8; i++) show(i, hex_seg[word[4*i +: 4]], 40);
  endtask

  initial begin
    resetn = 1'b0;
    an_i   = 8'hFF;
    seg_i  = 7'b1111111;
    repeat (4) @(negedge CLK100);
    check("rst_value", value_o, 32'h0);
    check("rst_blank", {24'h0, blank_o}, 32'hFF);
    check("rst_unknown", {24'h0, unknown_o}, 32'h0);
    check("rst_frame_valid", {31'h0, frame_valid_o}, 32'h0);
    check("rst_an_err", {31'h0, an_err_o}, 32'h0);
    resetn = 1'b1;
    idle(5);

    base = frame_cnt;
    scan(32'h12345678);
    idle(10);
    check("t1_frames", frame_cnt - base, 1);
    check("t1_value", last_val, 32'h12345678);
    check("t1_blank", {24'h0, last_blank}, 32'h0);
    check("t1_unknown", {24'h0, last_unk}, 32'h0);

    base = frame_cnt;
    show(0, hex_seg[8], 40);
    show(1, hex_seg[7], 40);
    show(2, hex_seg[6], 40);
    show(3, 7'b1111111, 40);
    show(4, hex_seg[4], 40);
    show(5, 7'b0110110, 40);
    show(6, hex_seg[2], 40);
    show(7, hex_seg[1], 40);
    idle(10);
    check("t2_frames", frame_cnt - base, 1);
    check("t2_value", last_val, 32'h12040678);
    check("t2_blank", {24'h0, last_blank}, 32'h08);
    check("t2_unknown", {24'h0, last_unk}, 32'h20);

    base = frame_cnt;
    for (int i = 0; i < 20; i++) show(0, hex_seg[i % 2 + 1], 5);
    idle(30);
    for (int i = 1; i < 8; i++) show(i, hex_seg[8 - i], 40);
    idle(10);
    check("t3_no_frame_without_digit0", frame_cnt - base, 0);
    show(0, hex_seg[10], 40);
    idle(10);
    check("t3_frame_after_digit0", frame_cnt - base, 1);
    check("t3_value", last_val, 32'h1234567A);

    check("t4_an_err_before", {31'h0, an_err_o}, 32'h0);
    an_i  = 8'hFC;
    seg_i = hex_seg[5];
    repeat (30) @(negedge CLK100);
    idle(10);
    check("t4_an_err_set", {31'h0, an_err_o}, 32'h1);
    base = frame_cnt;
    scan(32'hDEADBEEF);
    idle(10);
    check("t4_frames", frame_cnt - base, 1);
    check("t4_value", last_val, 32'hDEADBEEF);
    check("t4_an_err_sticky", {31'h0, an_err_o}, 32'h1);

    base = frame_cnt;
    show(0, hex_seg[3], 40);
    show(0, hex_seg[9], 40);
    for (int i = 1; i < 8; i++) show(i, hex_seg[8 - i], 40);
    idle(10);
    check("t5_frames", frame_cnt - base, 1);
    check("t5_value", last_val, 32'h12345679);

    for (int i = 0; i < 5; i++) show(i, hex_seg[8], 40);
    resetn = 1'b0;
    idle(5);
    check("t6_rst_value", value_o, 32'h0);
    check("t6_rst_blank", {24'h0, blank_o}, 32'hFF);
    check("t6_rst_an_err", {31'h0, an_err_o}, 32'h0);
    resetn = 1'b1;
    idle(5);
    base = frame_cnt;
    scan(32'hCAFE0001);
    idle(10);
    check("t6_frames", frame_cnt - base, 1);
    check("t6_value", last_val, 32'hCAFE0001);
    check("t6_an_err_clear", {31'h0, an_err_o}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
